// File: rtl/modulo_10_driver_if.sv
// modulo_10_driver_if: move request and counter command bundle between a requester and the mod-10 driver
interface modulo_10_driver_if;
   logic       start;
   logic [3:0] target;
   logic       abort;
   logic       w1;
   logic       w0;
   logic [3:0] count;
   logic       busy;
   logic       done;
   logic       err;
   modport master (output start, target, abort, input w1, w0, count, busy, done, err);
   modport slave (input start, target, abort, output w1, w0, count, busy, done, err);
endinterface

// File: rtl/modulo_10_driver.sv
// modulo_10_driver: steers a downstream mod-10 counter to a target digit; define MOD10_SHORTEST_PATH_EN to allow -1 steps
module modulo_10_driver (
   input logic               Clock,
   input logic               Reset,
   modulo_10_driver_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t     state, state_n;
   logic [3:0] count, count_n, tgt, tgt_n, d, step, stepped;
   logic [4:0] sum;
   logic [1:0] cmd, cmd_n, run_cmd;
   logic       done, done_n, err, err_n, go, accept, issue;
   assign go = state == IDLE && bus.start && !bus.abort;
   assign accept = go && bus.target <= 4'd9;
   assign issue = state == RUN && !bus.abort;
   assign d = tgt >= count ? tgt - count : tgt + 4'd10 - count;
`ifdef MOD10_SHORTEST_PATH_EN
   assign run_cmd = d == 4'd0 ? 2'b00 : d == 4'd1 ? 2'b01 : d >= 4'd7 ? 2'b11 : 2'b10;
`else
   assign run_cmd = d == 4'd0 ? 2'b00 : d == 4'd1 ? 2'b01 : 2'b10;
`endif
   // -1 is applied as +9 so every command is an addition modulo 10
   assign step = run_cmd == 2'b11 ? 4'd9 : {2'b00, run_cmd};
   assign sum = {1'b0, count} + {1'b0, step};
   assign stepped = sum >= 5'd10 ? 4'(sum - 5'd10) : sum[3:0];
   // state register together with the registered outputs
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
         count <= 4'd0;
         tgt <= 4'd0;
         cmd <= 2'b00;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         tgt <= tgt_n;
         cmd <= cmd_n;
         done <= done_n;
         err <= err_n;
      end
   end
   // next state: abort beats command issue, DONE always falls back to IDLE
   always_comb begin
      state_n = state == IDLE ? (accept ? RUN : IDLE)
              : state == RUN ? (bus.abort ? IDLE : d == 4'd0 ? DONE : RUN)
              : IDLE;
   end
   // next values of the registered outputs; count shadows the command being driven
   always_comb begin
      tgt_n = accept ? bus.target : tgt;
      err_n = go && bus.target > 4'd9;
      cmd_n = issue ? run_cmd : 2'b00;
      count_n = issue ? stepped : count;
      done_n = issue && d == 4'd0;
   end
   assign bus.w1 = cmd[1];
   assign bus.w0 = cmd[0];
   assign bus.count = count;
   assign bus.busy = state == RUN;
   assign bus.done = done;
   assign bus.err = err;
endmodule
